// File: rtl/pss_seq_ctrl.sv
// Point-sort stage sequencer: walks center points, pulses sort-core reset, gates Lop stream, tags LopLast.
// Latency: Start->Rst 1 cycle, Rst->STREAM 1 cycle; Lop valid/ready/last are zero-latency combinational gates.
// Backpressure: Lop ready mirrors PSS ready only in STREAM; DRAIN holds until MAPS_PER_CP map words have left PSS.
module pss_seq_ctrl #(
   parameter int IDX_WIDTH   = 10,
   parameter int LOP_WIDTH   = 32,
   parameter int MAPS_PER_CP = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 CCUPSS_Start,
   input  logic                 CCUPSS_Abort,
   input  logic [IDX_WIDTH-1:0] CCUPSS_CpNum,
   input  logic [IDX_WIDTH-1:0] CCUPSS_LopNum,
   output logic                 PSSCCU_Busy,
   output logic                 PSSCCU_Done,
   input  logic [LOP_WIDTH-1:0] KNNSEQ_Lop,
   input  logic                 KNNSEQ_LopVld,
   output logic                 SEQKNN_LopRdy,
   output logic [LOP_WIDTH-1:0] SEQPSS_Lop,
   output logic                 SEQPSS_LopVld,
   input  logic                 PSSSEQ_LopRdy,
   output logic                 SEQPSS_LopLast,
   output logic [IDX_WIDTH-1:0] SEQPSS_CpIdx,
   output logic                 SEQPSS_Rst,
   input  logic                 PSSCTR_MapVld,
   input  logic                 CTRPSS_MapRdy
);

   localparam int MAP_W = $clog2(MAPS_PER_CP + 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
   localparam logic [MAP_W-1:0]     MAP_ONE  = MAP_W'(1);
   localparam logic [MAP_W-1:0]     MAP_FULL = MAP_W'(MAPS_PER_CP);
   localparam logic [MAP_W-1:0]     MAP_PRE  = MAP_W'(MAPS_PER_CP - 1);

   typedef enum logic [2:0] {IDLE, RST, STREAM, DRAIN, DONE} state_t;

   state_t               state;
   logic [IDX_WIDTH-1:0] cpNum;
   logic [IDX_WIDTH-1:0] lopNum;
   logic [IDX_WIDTH-1:0] lopCnt;
   logic [MAP_W-1:0]     mapCnt;
   logic                 aborting;

   logic lopGate;
   logic lopIsLast;
   logic lopHs;
   logic mapHs;
   logic mapReached;

   // Abort blocks the Lop handshake in the very cycle it is raised, so no candidate slips into a flushed sort.
   assign lopGate        = (state == STREAM) && !CCUPSS_Abort;
   assign SEQPSS_Lop     = KNNSEQ_Lop;
   assign SEQPSS_LopVld  = lopGate && KNNSEQ_LopVld;
   assign SEQKNN_LopRdy  = lopGate && PSSSEQ_LopRdy;
   // LopLast qualifies a valid beat only; it never shows while the stream is idle.
   assign lopIsLast      = (lopCnt == (lopNum - IDX_ONE));
   assign SEQPSS_LopLast = SEQPSS_LopVld && lopIsLast;
   assign lopHs          = SEQPSS_LopVld && PSSSEQ_LopRdy;

   // Map words are only attributed to the current center point while it is streaming or draining.
   assign mapHs      = PSSCTR_MapVld && CTRPSS_MapRdy && ((state == STREAM) || (state == DRAIN));
   // The final map handshake counts as reached in the same cycle, saving one DRAIN cycle per center point.
   assign mapReached = (mapCnt == MAP_FULL) || (mapHs && (mapCnt == MAP_PRE));

   // Saturating count of map words that have left PSS for the current center point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mapCnt <= '0;
      end else if ((state == IDLE) || (state == RST)) begin
         mapCnt <= '0;
      end else if (mapHs && (mapCnt != MAP_FULL)) begin
         mapCnt <= mapCnt + MAP_ONE;
      end
   end

   // Batch FSM with registered Busy/Done/Rst/CpIdx; abort detours through one flushing RST cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cpNum        <= '0;
         lopNum       <= '0;
         lopCnt       <= '0;
         aborting     <= 1'b0;
         PSSCCU_Busy  <= 1'b0;
         PSSCCU_Done  <= 1'b0;
         SEQPSS_Rst   <= 1'b0;
         SEQPSS_CpIdx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (CCUPSS_Start) begin
                  cpNum        <= CCUPSS_CpNum;
                  lopNum       <= CCUPSS_LopNum;
                  SEQPSS_CpIdx <= '0;
                  lopCnt       <= '0;
                  PSSCCU_Busy  <= 1'b1;
                  if ((CCUPSS_CpNum == '0) || (CCUPSS_LopNum == '0)) begin
                     state       <= DONE;
                     PSSCCU_Done <= 1'b1;
                  end else begin
                     state      <= RST;
                     SEQPSS_Rst <= 1'b1;
                  end
               end
            end
            RST: begin
               lopCnt     <= '0;
               SEQPSS_Rst <= 1'b0;
               if (aborting) begin
                  state       <= IDLE;
                  aborting    <= 1'b0;
                  PSSCCU_Busy <= 1'b0;
               end else if (CCUPSS_Abort) begin
                  aborting   <= 1'b1;
                  SEQPSS_Rst <= 1'b1;
               end else begin
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (CCUPSS_Abort) begin
                  state      <= RST;
                  aborting   <= 1'b1;
                  SEQPSS_Rst <= 1'b1;
               end else if (lopHs) begin
                  lopCnt <= lopCnt + IDX_ONE;
                  if (lopIsLast) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (CCUPSS_Abort) begin
                  state      <= RST;
                  aborting   <= 1'b1;
                  SEQPSS_Rst <= 1'b1;
               end else if (mapReached) begin
                  if (SEQPSS_CpIdx == (cpNum - IDX_ONE)) begin
                     state       <= DONE;
                     PSSCCU_Done <= 1'b1;
                  end else begin
                     state        <= RST;
                     SEQPSS_Rst   <= 1'b1;
                     SEQPSS_CpIdx <= SEQPSS_CpIdx + IDX_ONE;
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               PSSCCU_Done <= 1'b0;
               PSSCCU_Busy <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               aborting    <= 1'b0;
               PSSCCU_Done <= 1'b0;
               PSSCCU_Busy <= 1'b0;
               SEQPSS_Rst  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pss_seq_ctrl.sv
// Directed bench for pss_seq_ctrl: a behavioural PSS returns MAPS_PER_CP map words after each LopLast.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
// Event counters are sampled on the falling edge, where the coming handshakes are already decided.
module tb_pss_seq_ctrl;
   localparam int IW  = 10;
   localparam int LW  = 32;
   localparam int MPC = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          CCUPSS_Start, CCUPSS_Abort;
   logic [IW-1:0] CCUPSS_CpNum, CCUPSS_LopNum;
   logic          PSSCCU_Busy, PSSCCU_Done;
   logic [LW-1:0] KNNSEQ_Lop;
   logic          KNNSEQ_LopVld, SEQKNN_LopRdy;
   logic [LW-1:0] SEQPSS_Lop;
   logic          SEQPSS_LopVld, PSSSEQ_LopRdy, SEQPSS_LopLast;
   logic [IW-1:0] SEQPSS_CpIdx;
   logic          SEQPSS_Rst;
   logic          PSSCTR_MapVld, CTRPSS_MapRdy;

   pss_seq_ctrl #(.IDX_WIDTH(IW), .LOP_WIDTH(LW), .MAPS_PER_CP(MPC)) dut (
      .clk(clk), .rst_n(rst_n),
      .CCUPSS_Start(CCUPSS_Start), .CCUPSS_Abort(CCUPSS_Abort),
      .CCUPSS_CpNum(CCUPSS_CpNum), .CCUPSS_LopNum(CCUPSS_LopNum),
      .PSSCCU_Busy(PSSCCU_Busy), .PSSCCU_Done(PSSCCU_Done),
      .KNNSEQ_Lop(KNNSEQ_Lop), .KNNSEQ_LopVld(KNNSEQ_LopVld), .SEQKNN_LopRdy(SEQKNN_LopRdy),
      .SEQPSS_Lop(SEQPSS_Lop), .SEQPSS_LopVld(SEQPSS_LopVld), .PSSSEQ_LopRdy(PSSSEQ_LopRdy),
      .SEQPSS_LopLast(SEQPSS_LopLast), .SEQPSS_CpIdx(SEQPSS_CpIdx), .SEQPSS_Rst(SEQPSS_Rst),
      .PSSCTR_MapVld(PSSCTR_MapVld), .CTRPSS_MapRdy(CTRPSS_MapRdy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int nCyc = 0;
   logic rndMode = 1'b0;

   // Observed events; written only by the monitor below.
   int rstCnt = 0, doneCnt = 0, lopHsCnt = 0, lastCnt = 0, mapBeats = 0, pending = 0;
   int payBad = 0, lastNoVld = 0, hsBad = 0;
   int rstIdx [64];
   int lastAt [64];

   // Snapshots taken at the start of each batch.
   int t0, bRst, bLop, bLast, bMap, bDone;

   always @(negedge clk) begin
      if (!rst_n) begin
         pending <= 0;
      end else begin
         if (SEQPSS_Rst) begin
            if (rstCnt < 64) rstIdx[rstCnt] <= int'(SEQPSS_CpIdx);
            rstCnt <= rstCnt + 1;
         end
         if (PSSCCU_Done) doneCnt <= doneCnt + 1;
         if (SEQPSS_LopVld && PSSSEQ_LopRdy) begin
            lopHsCnt <= lopHsCnt + 1;
            if (SEQPSS_LopLast) begin
               if (lastCnt < 64) lastAt[lastCnt] <= lopHsCnt + 1;
               lastCnt <= lastCnt + 1;
            end
         end
         if (PSSCTR_MapVld && CTRPSS_MapRdy) mapBeats <= mapBeats + 1;
         pending <= pending
                  + ((SEQPSS_LopVld && PSSSEQ_LopRdy && SEQPSS_LopLast) ? MPC : 0)
                  - ((PSSCTR_MapVld && CTRPSS_MapRdy) ? 1 : 0);
         if (SEQPSS_LopLast && !SEQPSS_LopVld) lastNoVld <= lastNoVld + 1;
         if (SEQPSS_Lop !== KNNSEQ_Lop) payBad <= payBad + 1;
         if ((KNNSEQ_LopVld && SEQKNN_LopRdy) !== (SEQPSS_LopVld && PSSSEQ_LopRdy)) hsBad <= hsBad + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: new stream stimulus shortly after the edge, then let combinational outputs settle.
   task automatic cyc();
      @(posedge clk);
      #1;
      nCyc++;
      KNNSEQ_Lop    = $urandom;
      KNNSEQ_LopVld = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
      PSSSEQ_LopRdy = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
      PSSCTR_MapVld = (pending > 0) && (rndMode ? ($urandom_range(0, 1) == 1) : 1'b1);
      CTRPSS_MapRdy = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
   endtask

   task automatic snap();
      t0 = nCyc; bRst = rstCnt; bLop = lopHsCnt; bLast = lastCnt; bMap = mapBeats; bDone = doneCnt;
   endtask

   task automatic waitDone(input int budget, input string tag);
      for (int i = 0; i < budget && !PSSCCU_Done; i++) cyc();
      chk(tag, PSSCCU_Done, 1'b1);
   endtask

   task automatic startBatch(input int cp, input int lop);
      CCUPSS_CpNum  = IW'(cp);
      CCUPSS_LopNum = IW'(lop);
      CCUPSS_Start  = 1'b1;
      snap();
      cyc();
      CCUPSS_Start  = 1'b0;
   endtask

   initial begin
      CCUPSS_Start = 1'b0; CCUPSS_Abort = 1'b0; CCUPSS_CpNum = '0; CCUPSS_LopNum = '0;
      KNNSEQ_Lop = '0; KNNSEQ_LopVld = 1'b1; PSSSEQ_LopRdy = 1'b1;
      PSSCTR_MapVld = 1'b0; CTRPSS_MapRdy = 1'b1;

      // Reset state, with peers asserting valid/ready so the gating is exercised.
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", PSSCCU_Busy, 0);
      chk("rst_done", PSSCCU_Done, 0);
      chk("rst_sortrst", SEQPSS_Rst, 0);
      chk("rst_cpidx", SEQPSS_CpIdx, 0);
      chk("rst_lopvld", SEQPSS_LopVld, 0);
      chk("rst_loprdy", SEQKNN_LopRdy, 0);
      chk("rst_loplast", SEQPSS_LopLast, 0);
      rst_n = 1'b1;
      cyc();

      // Batch 3 CPs x 4 Lops, no stalls: 13 cycles per CP (RST + 4 STREAM + 8 DRAIN), Done at Start+40.
      startBatch(3, 4);
      chk("b1_busy_t1", PSSCCU_Busy, 1);
      chk("b1_rst_t1", SEQPSS_Rst, 1);
      chk("b1_cpidx_t1", SEQPSS_CpIdx, 0);
      chk("b1_rdy_in_rst", SEQKNN_LopRdy, 0);
      cyc();
      chk("b1_rst_t2", SEQPSS_Rst, 0);
      chk("b1_rdy_t2", SEQKNN_LopRdy, 1);
      chk("b1_vld_t2", SEQPSS_LopVld, 1);
      chk("b1_last_t2", SEQPSS_LopLast, 0);
      waitDone(200, "b1_done_seen");
      chk("b1_latency", nCyc - t0, 40);
      chk("b1_maps", mapBeats - bMap, 24);
      chk("b1_cpidx_done", SEQPSS_CpIdx, 2);
      chk("b1_rst_pulses", rstCnt - bRst, 3);
      for (int k = 0; k < 3; k++) chk("b1_rst_cpidx", rstIdx[bRst + k], k);
      chk("b1_lops", lopHsCnt - bLop, 12);
      chk("b1_lasts", lastCnt - bLast, 3);
      for (int k = 0; k < 3; k++) chk("b1_last_pos", lastAt[bLast + k] - bLop, 4 * (k + 1));
      cyc();
      chk("b1_done_end", PSSCCU_Done, 0);
      chk("b1_busy_end", PSSCCU_Busy, 0);
      chk("b1_done_once", doneCnt - bDone, 1);

      // Batch 2 CPs x 5 Lops with random stalls on both streams.
      rndMode = 1'b1;
      startBatch(2, 5);
      waitDone(3000, "b2_done_seen");
      rndMode = 1'b0;
      chk("b2_lops", lopHsCnt - bLop, 10);
      chk("b2_lasts", lastCnt - bLast, 2);
      chk("b2_last_pos0", lastAt[bLast] - bLop, 5);
      chk("b2_last_pos1", lastAt[bLast + 1] - bLop, 10);
      chk("b2_maps", mapBeats - bMap, 16);
      chk("b2_rst_pulses", rstCnt - bRst, 2);
      chk("b2_last_no_vld", lastNoVld, 0);
      chk("b2_payload", payBad, 0);
      chk("b2_hs_pair", hsBad, 0);
      cyc();
      chk("b2_done_once", doneCnt - bDone, 1);

      // Empty batches: CpNum=0 then LopNum=0 both go straight to DONE.
      for (int k = 0; k < 2; k++) begin
         startBatch((k == 0) ? 0 : 5, (k == 0) ? 7 : 0);
         chk("e_done_t1", PSSCCU_Done, 1);
         chk("e_busy_t1", PSSCCU_Busy, 1);
         chk("e_rst_t1", SEQPSS_Rst, 0);
         chk("e_rdy_t1", SEQKNN_LopRdy, 0);
         cyc();
         chk("e_done_t2", PSSCCU_Done, 0);
         chk("e_busy_t2", PSSCCU_Busy, 0);
         chk("e_rdy_t2", SEQKNN_LopRdy, 0);
         chk("e_no_rst", rstCnt - bRst, 0);
         chk("e_no_lop", lopHsCnt - bLop, 0);
      end

      // Abort after 2 of 4 Lops: initial RST plus the flushing RST, IDLE two cycles after the abort.
      startBatch(2, 4);
      repeat (3) cyc();
      chk("a_lops_before", lopHsCnt - bLop, 2);
      CCUPSS_Abort = 1'b1;
      #1;
      chk("a_rdy_abort_cyc", SEQKNN_LopRdy, 0);
      chk("a_vld_abort_cyc", SEQPSS_LopVld, 0);
      cyc();
      CCUPSS_Abort = 1'b0;
      chk("a_rst_t1", SEQPSS_Rst, 1);
      chk("a_busy_t1", PSSCCU_Busy, 1);
      chk("a_rdy_t1", SEQKNN_LopRdy, 0);
      cyc();
      chk("a_busy_t2", PSSCCU_Busy, 0);
      chk("a_rst_t2", SEQPSS_Rst, 0);
      chk("a_rdy_t2", SEQKNN_LopRdy, 0);
      repeat (3) cyc();
      chk("a_no_done", doneCnt - bDone, 0);
      chk("a_rst_pulses", rstCnt - bRst, 2);
      chk("a_lops_total", lopHsCnt - bLop, 2);

      // Stray Start in DRAIN with different counts: 2 CPs x 3 Lops still run, Done at Start+25.
      startBatch(2, 3);
      repeat (4) cyc();
      CCUPSS_CpNum  = IW'(1);
      CCUPSS_LopNum = IW'(1);
      CCUPSS_Start  = 1'b1;
      cyc();
      CCUPSS_Start  = 1'b0;
      chk("s_busy", PSSCCU_Busy, 1);
      chk("s_no_rst", SEQPSS_Rst, 0);
      waitDone(200, "s_done_seen");
      chk("s_latency", nCyc - t0, 25);
      chk("s_lops", lopHsCnt - bLop, 6);
      chk("s_last_pos0", lastAt[bLast] - bLop, 3);
      chk("s_last_pos1", lastAt[bLast + 1] - bLop, 6);
      chk("s_rst_pulses", rstCnt - bRst, 2);
      chk("s_cpidx", SEQPSS_CpIdx, 1);
      cyc();

      // rst_n mid-DRAIN of CP1 (2 CPs x 2 Lops: CP1 DRAIN starts at Start+15).
      startBatch(2, 2);
      repeat (15) cyc();
      chk("r_cpidx_pre", SEQPSS_CpIdx, 1);
      chk("r_busy_pre", PSSCCU_Busy, 1);
      rst_n = 1'b0;
      #1;
      chk("r_busy", PSSCCU_Busy, 0);
      chk("r_done", PSSCCU_Done, 0);
      chk("r_sortrst", SEQPSS_Rst, 0);
      chk("r_cpidx", SEQPSS_CpIdx, 0);
      chk("r_lopvld", SEQPSS_LopVld, 0);
      chk("r_loprdy", SEQKNN_LopRdy, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      startBatch(2, 3);
      waitDone(200, "r2_done_seen");
      chk("r2_latency", nCyc - t0, 25);
      chk("r2_lops", lopHsCnt - bLop, 6);
      chk("r2_rst_pulses", rstCnt - bRst, 2);
      chk("r2_maps", mapBeats - bMap, 16);
      cyc();
      chk("r2_busy_end", PSSCCU_Busy, 0);
      chk("r2_done_once", doneCnt - bDone, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
